multi_inputconditioner: RTL

Parametrised, multi-channel successor to the single-pin input conditioner. Each channel synchronises an asynchronous pin into the clk domain, debounces it with a wait counter, and produces registered one-cycle rising and falling edge pulses. It sits between board-level pins (buttons, SPI chip-select/serial lines) and the synchronous logic. It adds a configurable synchroniser depth, a synchronous reset, and a per-channel glitch counter.

---
 rtl/multi_inputconditioner.sv | 104 ++++++++++
 1 files changed

// File: rtl/multi_inputconditioner.sv
`timescale 1ns/100ps
// multi_inputconditioner: per-channel pin synchroniser, debounce counter and registered edge pulses.
// Define INPUTCONDITIONER_GLITCHCNT_EN to add an 8-bit saturating rejected-glitch counter per channel.
module multi_inputconditioner #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int COUNTER_WIDTH = 3,
  parameter int WAIT_TIME     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   noisysignal,
  output logic [CHANNELS-1:0]   conditioned,
  output logic [CHANNELS-1:0]   positiveedge,
  output logic [CHANNELS-1:0]   negativeedge
`ifdef INPUTCONDITIONER_GLITCHCNT_EN
  ,
  output logic [8*CHANNELS-1:0] glitchcount
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] WAIT_LIMIT = COUNTER_WIDTH'(WAIT_TIME);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0]   sync_reg;
      logic                     s;
      logic [COUNTER_WIDTH-1:0] count_reg;
      logic [COUNTER_WIDTH-1:0] count_next;
      logic                     cond_reg;
      logic                     cond_next;
      logic                     pos_reg;
      logic                     pos_next;
      logic                     neg_reg;
      logic                     neg_next;

      // Plain flop chain; bit 0 is the metastability-exposed stage.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], noisysignal[gi]};
        end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_comb begin
        count_next = count_reg;
        cond_next  = cond_reg;
        pos_next   = 1'b0;
        neg_next   = 1'b0;
        if (s == cond_reg) begin
          count_next = '0;
        end else if (count_reg == WAIT_LIMIT) begin
          cond_next  = s;
          count_next = '0;
          pos_next   = s;
          neg_next   = ~s;
        end else begin
          count_next = count_reg + COUNTER_WIDTH'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg <= '0;
          cond_reg  <= 1'b0;
          pos_reg   <= 1'b0;
          neg_reg   <= 1'b0;
        end else begin
          count_reg <= count_next;
          cond_reg  <= cond_next;
          pos_reg   <= pos_next;
          neg_reg   <= neg_next;
        end
      end

      assign conditioned[gi]  = cond_reg;
      assign positiveedge[gi] = pos_reg;
      assign negativeedge[gi] = neg_reg;

`ifdef INPUTCONDITIONER_GLITCHCNT_EN
      logic [7:0] glitch_reg;
      logic       reject;

      // A rejected glitch is a partial count abandoned because s fell back to the accepted level.
      assign reject = (s == cond_reg) && (count_reg != '0);

      always_ff @(posedge clk) begin
        if (reset) begin
          glitch_reg <= '0;
        end else if (reject && (glitch_reg != 8'hFF)) begin
          glitch_reg <= glitch_reg + 8'd1;
        end
      end

      assign glitchcount[8*gi +: 8] = glitch_reg;
`endif
    end
  endgenerate

endmodule
